mw_cook_ctrl: RTL and testbench

Cooking-cycle controller for the microwave oven. It sequences keypad digit entry into a BCD time register and runs the start/stop/clear/door-interlock state machine. It generates the 1 s countdown and drives the magnetron enable and end-of-cycle buzzer. Its BCD digits feed the existing seven-segment decoders; its `mag_on` drives the magnetron output.

---
 rtl/mw_pkg.sv | 48 ++++
 rtl/mw_cook_ctrl_if.sv | 28 ++
 rtl/mw_edge_det.sv | 21 ++
 rtl/mw_cook_ctrl.sv | 124 ++++++++++++
 tb/tb_mw_cook_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mw_pkg.sv
// Shared types for the microwave cooking controller: state encoding, BCD time
// register layout and the BCD helper functions.
package mw_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCook  = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    typedef struct packed {
        bcd_t min;
        bcd_t tens;
        bcd_t ones;
    } cook_time_t;

    // Caller guarantees t != 0:00, so the minute digit never wraps.
    function automatic cook_time_t bcd_dec(cook_time_t t);
        cook_time_t r;
        r = t;
        if (t.ones != '0) begin
            r.ones = t.ones - bcd_t'(1);
        end else if (t.tens != '0) begin
            r.tens = t.tens - bcd_t'(1);
            r.ones = bcd_t'(9);
        end else begin
            r.min  = t.min - bcd_t'(1);
            r.tens = bcd_t'(5);
            r.ones = bcd_t'(9);
        end
        return r;
    endfunction

    function automatic bcd_t onehot_to_bcd(logic [9:0] k);
        bcd_t r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) r = bcd_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/mw_cook_ctrl_if.sv
// Panel-side signal bundle of the cooking controller: keypad, buttons, door
// switch in; BCD display digits, magnetron, buzzer and debug state out.
interface mw_cook_ctrl_if;
    import mw_pkg::*;

    logic [9:0] kbd;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    bcd_t       sec_ones;
    bcd_t       sec_tens;
    bcd_t       min;
    logic       mag_on;
    logic       buzz;
    logic [1:0] state;

    modport master (
        output kbd, startn, stopn, clearn, door_closed,
        input  sec_ones, sec_tens, min, mag_on, buzz, state
    );

    modport slave (
        input  kbd, startn, stopn, clearn, door_closed,
        output sec_ones, sec_tens, min, mag_on, buzz, state
    );

endinterface

// File: rtl/mw_edge_det.sv
// Registered rising-edge detector; callers invert active-low inputs so the
// reset value of zero means "released".
module mw_edge_det #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] level,
    output logic [W-1:0] pulse
);

    logic [W-1:0] level_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) level_q <= '0;
        else       level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/mw_cook_ctrl.sv
// Microwave cooking controller: keypad digit entry, start/stop/clear/door FSM,
// 1 s countdown prescaler, magnetron enable and end-of-cycle buzzer.
module mw_cook_ctrl
    import mw_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned DONE_SECS = 3
) (
    input logic          clk,
    input logic          rstn,
    mw_cook_ctrl_if.slave bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DONE_SECS > 1) ? $clog2(DONE_SECS) : 1;

    logic [9:0]    key_edge;
    logic [2:0]    btn_edge;
    logic          start_e, stop_e, clear_e, any_edge, tick, enter_run;
    state_e        state_q, state_d;
    cook_time_t    cook_q, cook_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] done_cnt_q, done_cnt_d;

    mw_edge_det #(.W(10)) u_kbd_edge (
        .clk   (clk),
        .rstn  (rstn),
        .level (bus.kbd),
        .pulse (key_edge)
    );

    mw_edge_det #(.W(3)) u_btn_edge (
        .clk   (clk),
        .rstn  (rstn),
        .level (~{bus.startn, bus.stopn, bus.clearn}),
        .pulse (btn_edge)
    );

    assign start_e  = btn_edge[2];
    assign stop_e   = btn_edge[1];
    assign clear_e  = btn_edge[0];
    assign any_edge = (|key_edge) | (|btn_edge);
    // Only meaningful in COOK/DONE; the prescaler is frozen elsewhere.
    assign tick     = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        cook_d  = cook_q;
        unique case (state_q)
            StIdle: begin
                if (clear_e || stop_e) begin
                    cook_d = '0;
                end else if (start_e && (cook_q != '0) && bus.door_closed) begin
                    state_d = StCook;
                end else if ($onehot(key_edge)) begin
                    cook_d = '{min: cook_q.tens, tens: cook_q.ones, ones: onehot_to_bcd(key_edge)};
                end
            end
            StCook: begin
                if (clear_e) begin
                    state_d = StIdle;
                    cook_d  = '0;
                end else if (stop_e || !bus.door_closed) begin
                    state_d = StPause;
                end else if (tick) begin
                    cook_d = bcd_dec(cook_q);
                    if (cook_d == '0) state_d = StDone;
                end
            end
            StPause: begin
                if (clear_e || stop_e) begin
                    state_d = StIdle;
                    cook_d  = '0;
                end else if (start_e && bus.door_closed) begin
                    state_d = StCook;
                end
            end
            StDone: begin
                cook_d = '0;
                if (any_edge || (tick && (done_cnt_q == DW'(DONE_SECS - 1)))) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign enter_run = (state_d != state_q) && ((state_d == StCook) || (state_d == StDone));

    always_comb begin
        presc_d    = presc_q;
        done_cnt_d = done_cnt_q;
        if (enter_run) begin
            presc_d = '0;
        end else if ((state_q == StCook) || (state_q == StDone)) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if ((state_d == StDone) && (state_q != StDone)) begin
            done_cnt_d = '0;
        end else if ((state_q == StDone) && tick) begin
            done_cnt_d = done_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cook_q     <= '0;
            presc_q    <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cook_q     <= cook_d;
            presc_q    <= presc_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign bus.sec_ones = cook_q.ones;
    assign bus.sec_tens = cook_q.tens;
    assign bus.min      = cook_q.min;
    assign bus.state    = state_q;
    assign bus.mag_on   = (state_q == StCook);
    assign bus.buzz     = (state_q == StDone);

endmodule

// File: tb/tb_mw_cook_ctrl.sv
// Self-checking bench for mw_cook_ctrl: scenario tasks push expected panel
// snapshots {state, min, tens, ones, mag_on, buzz} and pop them at sample time.
module tb_mw_cook_ctrl;

    localparam int unsigned TD = 100;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    mw_cook_ctrl_if bus ();

    mw_cook_ctrl #(.TICK_DIV(TD), .DONE_SECS(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] snap();
        return {bus.state, bus.min, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.buzz};
    endfunction

    function automatic logic [15:0] mk(int s, int m, int t, int o);
        return {2'(s), 4'(m), 4'(t), 4'(o), (s == 1), (s == 3)};
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(int d);
        bus.kbd = 10'(1) << d;
        step(1);
        bus.kbd = '0;
        step(1);
    endtask

    task automatic press_start();
        bus.startn = 1'b0; step(1); bus.startn = 1'b1; step(1);
    endtask

    task automatic press_stop();
        bus.stopn = 1'b0; step(1); bus.stopn = 1'b1; step(1);
    endtask

    task automatic press_clear();
        bus.clearn = 1'b0; step(1); bus.clearn = 1'b1; step(1);
    endtask

    task automatic test_reset();
        bus.kbd = '0; bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        bus.door_closed = 1'b1; rstn = 1'b0;
        sb.push_back('{"reset_held", mk(0, 0, 0, 0)});
        step(3);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        rstn = 1'b1;
        sb.push_back('{"reset_released", mk(0, 0, 0, 0)});
        step(2);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
    endtask

    task automatic test_full_cycle();
        key(1); key(2);
        sb.push_back('{"entry_0_12", mk(0, 0, 1, 2)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        press_start();
        sb.push_back('{"cook_start", mk(1, 0, 1, 2)});
        sb.push_back('{"cook_last_sec", mk(1, 0, 0, 1)});
        sb.push_back('{"done_entry", mk(3, 0, 0, 0)});
        sb.push_back('{"done_hold", mk(3, 0, 0, 0)});
        sb.push_back('{"done_exit", mk(0, 0, 0, 0)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(12 * TD - 2);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(3 * TD - 1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
    endtask

    task automatic test_stop_clear();
        key(3); key(5); press_start();
        step(5 * TD - 1);
        bus.stopn = 1'b0;
        sb.push_back('{"stop_pause", mk(2, 0, 3, 0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        bus.stopn = 1'b1;
        sb.push_back('{"pause_frozen", mk(2, 0, 3, 0)});
        step(2 * TD);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        press_clear();
        sb.push_back('{"pause_clear", mk(0, 0, 0, 0)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
    endtask

    task automatic test_door();
        key(1); key(2); key(9); press_start();
        step(3 * TD - 1);
        bus.door_closed = 1'b0;
        sb.push_back('{"door_open", mk(2, 1, 2, 6)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(150);
        bus.door_closed = 1'b1;
        sb.push_back('{"door_closed_alone", mk(2, 1, 2, 6)});
        step(5);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        press_start();
        sb.push_back('{"resume_first_tick", mk(1, 1, 2, 5)});
        step(TD - 1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        // Door opens in the cycle whose edge carries the next tick.
        step(TD - 1);
        bus.door_closed = 1'b0;
        sb.push_back('{"tick_discarded", mk(2, 1, 2, 5)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        bus.door_closed = 1'b1;
        press_clear();
    endtask

    task automatic test_borrow();
        key(7); key(2); press_start();
        sb.push_back('{"borrow_0_60", mk(1, 0, 6, 0)});
        sb.push_back('{"borrow_0_59", mk(1, 0, 5, 9)});
        step(12 * TD - 1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(TD);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        press_clear();
        key(1); key(0); key(0);
        sb.push_back('{"entry_1_00", mk(0, 1, 0, 0)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        press_start();
        sb.push_back('{"min_borrow", mk(1, 0, 5, 9)});
        step(TD - 1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        press_clear();
    endtask

    task automatic test_start_ignored();
        press_start();
        sb.push_back('{"start_at_zero", mk(0, 0, 0, 0)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        key(4);
        bus.door_closed = 1'b0;
        press_start();
        sb.push_back('{"start_door_open", mk(0, 0, 0, 4)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        bus.door_closed = 1'b1;
        press_clear();
    endtask

    task automatic test_keys();
        bus.kbd = 10'b00_0000_0110;
        step(1);
        bus.kbd = '0;
        sb.push_back('{"two_keys_ignored", mk(0, 0, 0, 0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        bus.kbd = 10'b00_0010_0000;
        step(50);
        bus.kbd = '0;
        sb.push_back('{"held_key_once", mk(0, 0, 0, 5)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        press_start();
        key(8);
        sb.push_back('{"key_in_cook", mk(1, 0, 0, 5)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(5 * TD - 3);
        sb.push_back('{"done_5s", mk(3, 0, 0, 0)});
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        bus.kbd = 10'b00_0000_1000;
        sb.push_back('{"done_key_exit", mk(0, 0, 0, 0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        bus.kbd = '0;
        step(1);
    endtask

    task automatic test_reset_midcook();
        key(9); press_start();
        step(10);
        rstn = 1'b0;
        sb.push_back('{"async_reset", mk(0, 0, 0, 0)});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, snap(), e.val); end
        step(2);
        rstn = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_stop_clear();
        test_door();
        test_borrow();
        test_start_ignored();
        test_keys();
        test_reset_midcook();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
